// File: rtl/sprite_line_fetch_ctrl.sv
// rtl/sprite_line_fetch_ctrl.sv - per-scanline sprite ROM fetch and line buffer writer (optional SPR_LINE_CLEAR_EN pre-clear)
module sprite_line_fetch_ctrl #(
    parameter int NUM_SPRITES = 8,
    parameter int LINE_W      = 224
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       line_start,
    input  logic [7:0]                 next_row,
    input  logic [NUM_SPRITES*8-1:0]   spr_col,
    input  logic [NUM_SPRITES*8-1:0]   spr_row,
    input  logic [NUM_SPRITES*6-1:0]   spr_num,
    input  logic [NUM_SPRITES-1:0]     spr_xflip,
    input  logic [NUM_SPRITES-1:0]     spr_yflip,
    output logic [11:0]                rom_addr,
    input  logic [7:0]                 rom_dout,
    output logic                       lb_we,
    output logic [7:0]                 lb_waddr,
    output logic [4:0]                 lb_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_SPRITES - 1);
    localparam logic [8:0] LINE_W9  = 9'(LINE_W);
    localparam logic [7:0] CLR_LAST = 8'(LINE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_EVAL,
        S_ADDR,
        S_CAPT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  g_q, g_d;
    logic [1:0]  k_q, k_d;
    logic [7:0]  byte_q, byte_d;
    logic [7:0]  clr_q, clr_d;

    // Shadow copy of the attributes, frozen for the whole line
    logic [7:0]  nrow_sh_q, nrow_sh_d;
    logic [7:0]  col_sh_q [NUM_SPRITES];
    logic [7:0]  col_sh_d [NUM_SPRITES];
    logic [7:0]  row_sh_q [NUM_SPRITES];
    logic [7:0]  row_sh_d [NUM_SPRITES];
    logic [5:0]  num_sh_q [NUM_SPRITES];
    logic [5:0]  num_sh_d [NUM_SPRITES];
    logic [NUM_SPRITES-1:0] xf_sh_q, xf_sh_d;
    logic [NUM_SPRITES-1:0] yf_sh_q, yf_sh_d;

    // Output registers
    logic [11:0] rom_addr_q, rom_addr_d;
    logic        lb_we_q, lb_we_d;
    logic [7:0]  lb_waddr_q, lb_waddr_d;
    logic [4:0]  lb_wdata_q, lb_wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;

    logic [7:0]  disp_cur;
    logic [7:0]  disp_n;
    logic [3:0]  r_n;
    logic [3:0]  c_n;
    logic [3:0]  sc_n;
    logic [8:0]  col_n;
    logic [1:0]  pix_n;

    // Next-state: snapshot on acceptance, then walk sprites high index to low
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        g_d       = g_q;
        k_d       = k_q;
        byte_d    = byte_q;
        clr_d     = clr_q;
        nrow_sh_d = nrow_sh_q;
        col_sh_d  = col_sh_q;
        row_sh_d  = row_sh_q;
        num_sh_d  = num_sh_q;
        xf_sh_d   = xf_sh_q;
        yf_sh_d   = yf_sh_q;
        overrun_d = line_start && (state_q != S_IDLE);
        disp_cur  = nrow_sh_q - row_sh_q[idx_q];

        case (state_q)
            S_IDLE: begin
                if (line_start) begin
                    nrow_sh_d = next_row;
                    for (int i = 0; i < NUM_SPRITES; i++) begin
                        col_sh_d[i] = spr_col[i*8 +: 8];
                        row_sh_d[i] = spr_row[i*8 +: 8];
                        num_sh_d[i] = spr_num[i*6 +: 6];
                    end
                    xf_sh_d = spr_xflip;
                    yf_sh_d = spr_yflip;
                    idx_d   = LAST_IDX;
                    clr_d   = 8'd0;
`ifdef SPR_LINE_CLEAR_EN
                    state_d = S_CLEAR;
`else
                    state_d = S_EVAL;
`endif
                end
            end
            S_CLEAR: begin
                if (clr_q == CLR_LAST) begin
                    state_d = S_EVAL;
                end else begin
                    clr_d = clr_q + 8'd1;
                end
            end
            S_EVAL: begin
                if (disp_cur < 8'd16) begin
                    state_d = S_ADDR;
                    g_d     = 2'd0;
                end else if (idx_q == 3'd0) begin
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q - 3'd1;
                end
            end
            S_ADDR: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                byte_d  = rom_dout;
                k_d     = 2'd0;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    if (g_q != 2'd3) begin
                        g_d     = g_q + 2'd1;
                        state_d = S_ADDR;
                    end else if (idx_q == 3'd0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q - 3'd1;
                        state_d = S_EVAL;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so every output leaves a flop
    always_comb begin
        disp_n     = nrow_sh_d - row_sh_d[idx_d];
        r_n        = yf_sh_d[idx_d] ? (4'd15 - disp_n[3:0]) : disp_n[3:0];
        c_n        = {g_d, k_d};
        sc_n       = xf_sh_d[idx_d] ? (4'd15 - c_n) : c_n;
        col_n      = {1'b0, col_sh_d[idx_d]} + {5'b0, sc_n};
        pix_n      = byte_d[{k_d, 1'b0} +: 2];

        rom_addr_d = rom_addr_q;
        lb_we_d    = 1'b0;
        lb_waddr_d = lb_waddr_q;
        lb_wdata_d = lb_wdata_q;
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);

        case (state_d)
            S_ADDR: begin
                rom_addr_d = {num_sh_d[idx_d], r_n, g_d};
            end
            S_WRITE: begin
                lb_we_d    = (pix_n != 2'd0) && (col_n < LINE_W9);
                lb_waddr_d = col_n[7:0];
                lb_wdata_d = {idx_d, pix_n};
            end
            S_CLEAR: begin
                lb_we_d    = 1'b1;
                lb_waddr_d = clr_d;
                lb_wdata_d = 5'd0;
            end
            default: begin
                lb_we_d = 1'b0;
            end
        endcase
    end

    // State, shadow and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            g_q        <= 2'd0;
            k_q        <= 2'd0;
            byte_q     <= 8'd0;
            clr_q      <= 8'd0;
            nrow_sh_q  <= 8'd0;
            for (int i = 0; i < NUM_SPRITES; i++) begin
                col_sh_q[i] <= 8'd0;
                row_sh_q[i] <= 8'd0;
                num_sh_q[i] <= 6'd0;
            end
            xf_sh_q    <= '0;
            yf_sh_q    <= '0;
            rom_addr_q <= 12'd0;
            lb_we_q    <= 1'b0;
            lb_waddr_q <= 8'd0;
            lb_wdata_q <= 5'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            g_q        <= g_d;
            k_q        <= k_d;
            byte_q     <= byte_d;
            clr_q      <= clr_d;
            nrow_sh_q  <= nrow_sh_d;
            col_sh_q   <= col_sh_d;
            row_sh_q   <= row_sh_d;
            num_sh_q   <= num_sh_d;
            xf_sh_q    <= xf_sh_d;
            yf_sh_q    <= yf_sh_d;
            rom_addr_q <= rom_addr_d;
            lb_we_q    <= lb_we_d;
            lb_waddr_q <= lb_waddr_d;
            lb_wdata_q <= lb_wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign rom_addr = rom_addr_q;
    assign lb_we    = lb_we_q;
    assign lb_waddr = lb_waddr_q;
    assign lb_wdata = lb_wdata_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_sprite_line_fetch_ctrl.sv
// tb/tb_sprite_line_fetch_ctrl.sv - self-checking bench for sprite_line_fetch_ctrl
module tb_sprite_line_fetch_ctrl;

    localparam int NS = 8;
    localparam int LW = 224;
`ifdef SPR_LINE_CLEAR_EN
    localparam int CLR = LW;
`else
    localparam int CLR = 0;
`endif

    logic        clk;
    logic        rst;
    logic        line_start;
    logic [7:0]  next_row;
    logic [63:0] spr_col;
    logic [63:0] spr_row;
    logic [47:0] spr_num;
    logic [7:0]  spr_xflip;
    logic [7:0]  spr_yflip;
    logic [11:0] rom_addr;
    logic [7:0]  rom_dout;
    logic        lb_we;
    logic [7:0]  lb_waddr;
    logic [4:0]  lb_wdata;
    logic        busy;
    logic        done;
    logic        overrun;

    sprite_line_fetch_ctrl #(.NUM_SPRITES(NS), .LINE_W(LW)) dut (
        .clk(clk), .rst(rst), .line_start(line_start), .next_row(next_row),
        .spr_col(spr_col), .spr_row(spr_row), .spr_num(spr_num),
        .spr_xflip(spr_xflip), .spr_yflip(spr_yflip),
        .rom_addr(rom_addr), .rom_dout(rom_dout),
        .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always begin
        clk = 1'b0; #5;
        clk = 1'b1; #5;
    end

    // Synchronous ROM, one cycle of latency
    logic [7:0] rom_mem [4096];
    always @(posedge clk) rom_dout <= rom_mem[rom_addr];

    int tests;
    int fails;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Line configuration and expected per-cycle behaviour
    int cfg_row [NS];
    int cfg_col [NS];
    int cfg_num [NS];
    int cfg_xf  [NS];
    int cfg_yf  [NS];
    int cfg_next;
    int exp_we [512];
    int exp_wa [512];
    int exp_wd [512];
    int exp_ra [512];
    int exp_lat;
    int first_ra_cyc;
    int obs_lat;
    int obs_wr;
    int obs_addr0;
    logic [4:0] lb_mem [256];

    // Schedule from the cost rules: miss = 1 cycle, hit = 1 + 4 groups of 6
    task automatic build_expected();
        int t, d, r, a, b, c, pix, col, cyc;
        for (int n = 0; n < 512; n++) begin
            exp_we[n] = 0; exp_wa[n] = 0; exp_wd[n] = 0; exp_ra[n] = -1;
        end
        first_ra_cyc = -1;
        for (int n = 1; n <= CLR; n++) begin
            exp_we[n] = 1; exp_wa[n] = n - 1;
        end
        t = 1 + CLR;
        for (int s = NS - 1; s >= 0; s--) begin
            d = (cfg_next - cfg_row[s]) & 255;
            if (d < 16) begin
                r = (cfg_yf[s] != 0) ? 15 - d : d;
                for (int g = 0; g < 4; g++) begin
                    a = cfg_num[s] * 64 + r * 4 + g;
                    exp_ra[t + 1 + 6 * g] = a;
                    if (first_ra_cyc < 0) first_ra_cyc = t + 1;
                    b = int'(rom_mem[a]);
                    for (int k = 0; k < 4; k++) begin
                        c   = 4 * g + k;
                        pix = (b >> (2 * k)) & 3;
                        col = cfg_col[s] + ((cfg_xf[s] != 0) ? 15 - c : c);
                        cyc = t + 3 + 6 * g + k;
                        if (pix != 0 && col < LW) begin
                            exp_we[cyc] = 1; exp_wa[cyc] = col; exp_wd[cyc] = s * 4 + pix;
                        end
                    end
                end
                t += 25;
            end else begin
                t += 1;
            end
        end
        exp_lat = t;
    endtask

    task automatic set_default();
        for (int s = 0; s < NS; s++) begin
            cfg_row[s] = 100; cfg_col[s] = 0; cfg_num[s] = 0; cfg_xf[s] = 0; cfg_yf[s] = 0;
        end
        cfg_next = 50;
    endtask

    task automatic drive_cfg();
        next_row = 8'(cfg_next);
        for (int s = 0; s < NS; s++) begin
            spr_col[s*8 +: 8] = 8'(cfg_col[s]);
            spr_row[s*8 +: 8] = 8'(cfg_row[s]);
            spr_num[s*6 +: 6] = 6'(cfg_num[s]);
            spr_xflip[s]      = (cfg_xf[s] != 0);
            spr_yflip[s]      = (cfg_yf[s] != 0);
        end
    endtask

    // One full line: accept, then compare every cycle through one idle cycle
    task automatic run_line(input int ovr_req);
        int ovr_at;
        build_expected();
        ovr_at = (ovr_req == -2) ? int'($urandom_range(1, exp_lat - 1)) : ovr_req;
        @(negedge clk);
        drive_cfg();
        line_start = 1'b1;
        obs_lat = 0; obs_wr = 0; obs_addr0 = -1;
        for (int n = 1; n <= exp_lat + 1; n++) begin
            @(negedge clk);
            line_start = (n == ovr_at);
            if (n == 1) begin
                spr_col   = {$urandom, $urandom};
                spr_row   = {$urandom, $urandom};
                spr_num   = 48'({$urandom, $urandom});
                spr_xflip = 8'($urandom);
                spr_yflip = 8'($urandom);
                next_row  = 8'($urandom);
            end
            chk($sformatf("busy@%0d", n), int'(busy), int'(n <= exp_lat));
            chk($sformatf("done@%0d", n), int'(done), int'(n == exp_lat));
            chk($sformatf("overrun@%0d", n), int'(overrun), int'(n == ovr_at + 1));
            chk($sformatf("lb_we@%0d", n), int'(lb_we), exp_we[n]);
            if (exp_we[n] != 0) begin
                chk($sformatf("lb_waddr@%0d", n), int'(lb_waddr), exp_wa[n]);
                chk($sformatf("lb_wdata@%0d", n), int'(lb_wdata), exp_wd[n]);
            end
            if (exp_ra[n] >= 0) chk($sformatf("rom_addr@%0d", n), int'(rom_addr), exp_ra[n]);
            if (done && obs_lat == 0) obs_lat = n;
            if (lb_we) begin
                obs_wr++;
                lb_mem[lb_waddr] = lb_wdata;
            end
            if (n == first_ra_cyc) obs_addr0 = int'(rom_addr);
        end
        line_start = 1'b0;
    endtask

    typedef struct {
        int next_row;
        int row3;
        int col3;
        int xf;
        int yf;
        int all_hit;
        int exp_lat;
        int exp_writes;
        int exp_addr0;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int seen;
        tests = 0; fails = 0;
        rst = 1'b1; line_start = 1'b0; next_row = 8'd0;
        spr_col = '0; spr_row = '0; spr_num = '0; spr_xflip = '0; spr_yflip = '0;
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'hE4;
        for (int i = 0; i < 256; i++) lb_mem[i] = 5'h1F;

        vecs[0] = '{50, 100,  10, 0, 0, 0,   9,  0, 12'h000};
        vecs[1] = '{42,  40,  10, 0, 0, 0,  33, 12, 12'h148};
        vecs[2] = '{42,  40,  10, 1, 1, 0,  33, 12, 12'h174};
        vecs[3] = '{42,  40, 216, 0, 0, 0,  33,  6, 12'h148};
        vecs[4] = '{42,  40, 250, 0, 0, 0,  33,  0, 12'h148};
        vecs[5] = '{42,  27,  10, 0, 0, 0,  33, 12, 12'h17C};
        vecs[6] = '{42,  26,  10, 0, 0, 0,   9,  0, 12'h000};
        vecs[7] = '{ 3, 250,   0, 0, 0, 0,  33, 12, 12'h164};
        vecs[8] = '{42,  40, 100, 0, 0, 1, 201, 96, 12'h148};

        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_lb_we", int'(lb_we), 0);
        chk("rst_overrun", int'(overrun), 0);
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_lb_waddr", int'(lb_waddr), 0);
        rst = 1'b0;

        // Directed table
        for (int v = 0; v < 9; v++) begin
            set_default();
            cfg_next = vecs[v].next_row;
            for (int s = 0; s < NS; s++) begin
                if (s == 3 || vecs[v].all_hit != 0) begin
                    cfg_row[s] = vecs[v].row3; cfg_col[s] = vecs[v].col3; cfg_num[s] = 5;
                    cfg_xf[s]  = vecs[v].xf;   cfg_yf[s]  = vecs[v].yf;
                end
            end
            run_line(-1);
            chk($sformatf("vec%0d_latency", v), obs_lat, vecs[v].exp_lat + CLR);
            chk($sformatf("vec%0d_writes", v), obs_wr, vecs[v].exp_writes + CLR);
            if (vecs[v].exp_lat > 9) chk($sformatf("vec%0d_addr0", v), obs_addr0, vecs[v].exp_addr0);
        end

        // Overlapping sprites 0 and 1: index 0 must win every shared column
        set_default();
        cfg_next = 42;
        for (int s = 0; s < 2; s++) begin
            cfg_row[s] = 40; cfg_col[s] = 30; cfg_num[s] = 5 + s;
        end
        for (int i = 0; i < 256; i++) lb_mem[i] = 5'h1F;
        run_line(-1);
        chk("overlap_col30", int'(lb_mem[30]), (CLR != 0) ? 0 : 31);
        chk("overlap_col31", int'(lb_mem[31]), 1);
        chk("overlap_col32", int'(lb_mem[32]), 2);
        chk("overlap_col33", int'(lb_mem[33]), 3);
        chk("overlap_col45", int'(lb_mem[45]), 3);

        // Right-edge sprite with a line_start pulse in the middle of the fetch
        set_default();
        cfg_next = 42; cfg_row[3] = 40; cfg_col[3] = 216; cfg_num[3] = 5;
        run_line(CLR + 10);
        chk("ovr_latency", obs_lat, 33 + CLR);
        chk("ovr_writes", obs_wr, 6 + CLR);

        // Reset during the write phase, then a normal line
        set_default();
        cfg_next = 42; cfg_row[3] = 40; cfg_col[3] = 10; cfg_num[3] = 5;
        @(negedge clk);
        drive_cfg();
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            if (lb_we) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("rst_mid_reached_write", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_lb_we", int'(lb_we), 0);
        chk("rst_mid_done", int'(done), 0);
        rst = 1'b0;
        run_line(-1);
        chk("after_rst_latency", obs_lat, 33 + CLR);

        // Randomised lines against the schedule model
        for (int it = 0; it < 40; it++) begin
            for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
            cfg_next = int'($urandom_range(0, 255));
            for (int s = 0; s < NS; s++) begin
                cfg_row[s] = (cfg_next - int'($urandom_range(0, 21))) & 255;
                cfg_col[s] = int'($urandom_range(0, 255));
                cfg_num[s] = int'($urandom_range(0, 63));
                cfg_xf[s]  = int'($urandom_range(0, 1));
                cfg_yf[s]  = int'($urandom_range(0, 1));
            end
            run_line((it % 4 == 0) ? -2 : -1);
            chk($sformatf("rand%0d_latency", it), obs_lat, exp_lat);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_line_fetch_ctrl.md
Name: sprite_line_fetch_ctrl

Overview:
- Per-scanline sprite scheduler that sequences the sprite ROM on behalf of the sprite renderer.
- On each `line_start` it snapshots the sprite attribute registers and evaluates every sprite against the next display row.
- For each hit it fetches the sprite's four ROM bytes for that row and writes the non-transparent pixels into a scanline buffer. The display side reads that buffer.
- It replaces the per-pixel ROM lookup with a line-buffered fetch performed during horizontal blanking.

Parameters:
- NUM_SPRITES, 8, number of hardware sprites; index 0 has highest priority.
- LINE_W, 224, visible pixels per line; buffer addresses 0..LINE_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- line_start  in  1  one-cycle request to build the buffer for next_row
- next_row  in  8  screen row (already remapped) to build
- spr_col  in  NUM_SPRITES*8  per-sprite screen column of left edge (already remapped)
- spr_row  in  NUM_SPRITES*8  per-sprite screen row of top edge
- spr_num  in  NUM_SPRITES*6  per-sprite ROM sprite number
- spr_xflip  in  NUM_SPRITES  per-sprite x flip (global flip already applied)
- spr_yflip  in  NUM_SPRITES  per-sprite y flip (global flip already applied)
- rom_addr  out  12  sprite ROM address; ROM is synchronous with 1-cycle latency
- rom_dout  in  8  sprite ROM data
- lb_we  out  1  line buffer write enable
- lb_waddr  out  8  line buffer column
- lb_wdata  out  5  {sprite index[2:0], pixel[1:0]}
- busy  out  1  high from the cycle after acceptance through the DONE cycle
- done  out  1  one-cycle pulse, buffer complete
- overrun  out  1  one-cycle pulse when line_start arrives while busy

Behaviour:
- Reset: synchronous. State=IDLE; all outputs 0; shadow registers 0. Asserting rst mid-operation aborts the operation and completes no further writes.
- Outputs are Moore-decoded from registered state only. There are no combinational paths from inputs to outputs, except `rom_dout`, which feeds only internal registers.
- Acceptance: a `line_start` sampled high in IDLE snapshots `next_row` and all `spr_*` inputs into shadow registers. Next state is EVAL with idx=NUM_SPRITES-1. Later changes to the `spr_*` inputs do not affect the line in progress.
- `line_start` sampled high in any state other than IDLE is ignored and raises `overrun` for one cycle.
- FSM, evaluating one sprite per EVAL cycle:
  - EVAL: disp = next_row - spr_row[idx], computed 8-bit modulo 256. The sprite hits if disp < 16. On a hit, go to ADDR with g=0. On a miss, go to DONE if idx==0, else to EVAL with idx-1.
  - ADDR: r = yflip ? 15-disp[3:0] : disp[3:0]. rom_addr = {spr_num[idx], r, g[1:0]}. Next state is CAPT.
  - CAPT: register rom_dout into byte_q. Next state is WRITE with k=0.
  - WRITE (k=0..3, one cycle each):
    - pix = byte_q[2k+1:2k].
    - c = 4g+k; sprite column sc = xflip ? 15-c : c.
    - col = spr_col[idx] + sc, computed 9-bit.
    - lb_we=1 only if pix!=0 and col < LINE_W.
    - lb_waddr = col[7:0]; lb_wdata = {idx, pix}.
    - After k=3: if g<3, go to ADDR with g+1; else go to DONE if idx==0, else to EVAL with idx-1.
  - DONE: done=1 for one cycle, then IDLE.
- Priority: sprites are processed from the highest index down to 0, so a lower index overwrites a higher one at the same column. Transparent pixels (0) are never written.
- Timing:
  - A missed sprite costs 1 cycle; a hit sprite costs 25 cycles (1 + 4×6).
  - With no hits, `done` asserts exactly 9 cycles after the acceptance cycle.
  - With all 8 sprites hitting, `done` asserts exactly 201 cycles after the acceptance cycle.
- Right-edge clip: a column carry past 255, or col >= LINE_W, suppresses the write. There is no wrap to column 0.

Optional Feature:
- SPR_LINE_CLEAR_EN
- Defined: acceptance enters CLEAR instead of EVAL. CLEAR writes lb_we=1, lb_wdata=0 to lb_waddr 0..LINE_W-1, one address per cycle, then enters EVAL with idx=NUM_SPRITES-1. All latencies grow by LINE_W (no hits: done at cycle 233).
- Undefined: the buffer is not cleared by this block; the display side clears it on read.

Test Plan:
- All spr_row=100, next_row=50, line_start pulse -> lb_we never asserted; done high exactly 9 cycles after acceptance; busy high for cycles 1..9.
- Sprite 3: row=40, col=10, num=5, no flips; next_row=42; ROM bytes at {5,2,g} = 8'hE4 for all g -> rom_addr sequence 0x148..0x14B; writes cols 10..25 with pix pattern 0,1,2,3 repeated, where pix 0 is not written (12 writes, lb_wdata upper bits = 3).
- Same stimulus with xflip=1 and yflip=1 -> rom_addr uses r=13 (0x174..0x177); pix for col 25-c written in place of col 10+c.
- Sprites 0 and 1 overlap at the same col/row with nonzero pixels -> final write at each shared column carries index 0; sprite 1 writes occur earlier.
- Sprite col=216 hitting -> writes only to cols 216..223; a pulse of line_start mid-fetch -> overrun=1 for one cycle, sequence unaffected.
- rst asserted mid-WRITE -> next cycle busy=0, lb_we=0, done=0; a following line_start is accepted normally.
